instruction_encoder_loader: RTL and testbench
=============================================

// Module: instruction_encoder_loader
// PURPOSE
//  Inverse of the CPU's instruction decode path: accepts field-level instruction requests (R/I/J/branch),
//  packs them into 32-bit MIPS words, resolves PC-relative branch offsets and J-type pseudo-direct targets
//  against its own load PC, and writes each word into instruction memory sequentially. Used by test
//  harnesses / boot logic to fill imem before the CPU is released from reset.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of first word written after load
//  DEPTH      1024           max words accepted before full
// PORTS
//  clk          in   1   clock
//  reset        in   1   asynchronous, active-high reset
//  load         in   1   pulse: pc<=BASE_ADDR, count<=0, clear err_flag, abort any op
//  in_valid     in   1   request valid
//  in_ready     out  1   = (state==IDLE) && !full && !load
//  fmt          in   2   00 R, 01 I (imm literal), 10 J, 11 BR (I-type, imm from tgt)
//  op / funct   in   6   opcode / function
//  rs, rt, rd   in   5   register fields
//  shamt        in   5   shift amount
//  imm          in   16  immediate (fmt 01)
//  tgt          in   32  absolute byte target (fmt 10/11)
//  imem_we      out  1   one-cycle write strobe
//  imem_addr    out  32  byte address of write (= pc)
//  imem_wdata   out  32  encoded word
//  imem_re      out  1   readback strobe (READBACK_CHECK_EN only, else 0)
//  imem_rdata   in   32  readback data, valid cycle after imem_re
//  pc           out  32  next write address
//  count        out  $clog2(DEPTH+1) words written
//  full         out  1   count==DEPTH
//  err_valid    out  1   one-cycle pulse on rejected/failed instruction
//  err_code     out  3   001 misaligned tgt, 010 branch range, 011 jump region, 100 readback mismatch
//  err_flag     out  1   sticky OR of err_valid; cleared only by load/reset
// BEHAVIOUR
//  Reset: state IDLE, pc=BASE_ADDR, count=0, all strobes/err outputs 0, imem_wdata=0.
//  FSM IDLE -> ENC -> WR -> IDLE. Handshake in_valid&&in_ready in IDLE captures all fields.
//  ENC: word formed combinationally from captured fields and registered:
//   R: {op,rs,rt,rd,shamt,funct}; I: {op,rs,rt,imm}; J: {op,tgt[27:2]};
//   BR: diff=tgt-(pc+4) (32-bit, wrap), imm=diff[17:2];
//   checks: tgt[1:0]!=0 (fmt 10/11) -> 001; BR diff signed outside [-2^17, 2^17-4] -> 010;
//   J tgt[31:28]!=(pc+4)[31:28] -> 011. Priority 001>010>011.
//   Error: err_valid=1 next cycle, err_code held until next error, no write, pc/count unchanged, ->IDLE.
//  WR: imem_we=1 for exactly one cycle with imem_addr=pc, imem_wdata=word; on exit pc+=4 (wraps
//   0xFFFFFFFC->0), count+=1. Latency accept->imem_we = 2 cycles; throughput 1 word / 3 cycles.
//  full: in_ready=0, requests stall (not dropped); only load clears.
//  load in any state: wins over in_valid, aborts ENC/WR (a WR in same cycle is suppressed), -> IDLE.
//  Reset mid-op: immediate return to reset values; partially captured request lost.
// CONFIGURATION
//  `READBACK_CHECK_EN defined: WR -> RD -> CMP -> IDLE. RD asserts imem_re one cycle at same addr;
//   CMP compares imem_rdata to word; mismatch -> err_valid, err_code=100 (pc/count still advanced).
//   Throughput 1 word / 5 cycles.
//  Not defined: imem_re tied 0, imem_rdata unused, RD/CMP states absent.
// STRUCTURE
//  Package instr_pkg: fmt codes, opcode consts (OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_ADDI=8),
//   err codes, FSM state encoding. Shared with decode side.
//  Sub-module instruction_field_packer: pure combinational pack + range checks (fields, pc -> word, err).
//  Top holds FSM, capture regs, pc/count, err logic.
// TESTING
//  R: pc=0, fmt=00 op=0 rs=8 rt=9 rd=10 shamt=0 funct=0x20 -> imem_we @+2, addr 0x0, data 0x01095020.
//  I: next, fmt=01 op=8 rs=0 rt=8 imm=5 -> addr 0x4, data 0x20080005; count=2.
//  BR: pc=0x8, fmt=11 op=5 rs=8 rt=9 tgt=0x0 -> addr 0x8, data 0x1509FFFD.
//  J: pc=0xC, fmt=10 op=2 tgt=0x40 -> data 0x08000010; then tgt=0x10000000 -> err_valid, code 011, no we, pc=0x10.
//  DEPTH=4: 4 writes -> full=1, in_ready=0 with in_valid held; load -> pc=BASE_ADDR, count=0, full=0, err_flag=0.
//  READBACK_CHECK_EN: memory model corrupts bit0 -> err_code 100, pc still advanced; load mid-WR -> no imem_we.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared MIPS encode/decode definitions: format codes, opcodes, error codes, loader FSM states.
// READBACK_CHECK_EN adds the readback states RD/CMP.
package instr_pkg;

    typedef enum logic [1:0] {
        FMT_R  = 2'b00,
        FMT_I  = 2'b01,
        FMT_J  = 2'b10,
        FMT_BR = 2'b11
    } fmt_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    localparam logic [2:0] ERR_NONE    = 3'b000;
    localparam logic [2:0] ERR_ALIGN   = 3'b001;
    localparam logic [2:0] ERR_BRANGE  = 3'b010;
    localparam logic [2:0] ERR_JREGION = 3'b011;
    localparam logic [2:0] ERR_RDBACK  = 3'b100;

`ifdef READBACK_CHECK_EN
    typedef enum logic [2:0] {ST_IDLE, ST_ENC, ST_WR, ST_RD, ST_CMP} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ENC, ST_WR} state_e;
`endif

    // Offset fits the 16-bit word field when bits 31..17 are all sign copies.
    function automatic logic br_in_range(input logic [31:0] diff);
        return diff[31:17] == {15{diff[17]}};
    endfunction

endpackage

// File: rtl/instruction_field_packer.sv
// Combinational MIPS word packer with target alignment / branch range / jump region checks.
// Branch and jump targets are resolved against pc_i + 4.
module instruction_field_packer
    import instr_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [31:0] tgt_i,
    input  logic [31:0] pc_i,
    output logic [31:0] word_o,
    output logic        err_o,
    output logic [2:0]  code_o
);

    logic [31:0] pc4;
    logic [31:0] diff;

    assign pc4  = pc_i + 32'd4;
    assign diff = tgt_i - pc4;

    always_comb begin
        word_o = '0;
        unique case (fmt_e'(fmt_i))
            FMT_R:  word_o = {op_i, rs_i, rt_i, rd_i, shamt_i, funct_i};
            FMT_I:  word_o = {op_i, rs_i, rt_i, imm_i};
            FMT_J:  word_o = {op_i, tgt_i[27:2]};
            FMT_BR: word_o = {op_i, rs_i, rt_i, diff[17:2]};
            default: word_o = '0;
        endcase
    end

    always_comb begin
        code_o = ERR_NONE;
        if (fmt_i[1] && (tgt_i[1:0] != 2'b00)) begin
            code_o = ERR_ALIGN;
        end else if ((fmt_i == FMT_BR) && !br_in_range(diff)) begin
            code_o = ERR_BRANGE;
        end else if ((fmt_i == FMT_J) && (tgt_i[31:28] != pc4[31:28])) begin
            code_o = ERR_JREGION;
        end
    end

    assign err_o = (code_o != ERR_NONE);

endmodule

// File: rtl/instruction_encoder_loader.sv
// Field-level instruction encoder that writes packed MIPS words into imem sequentially.
// Define READBACK_CHECK_EN to read each word back and flag mismatches.
module instruction_encoder_loader
    import instr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   fmt,
    input  logic [5:0]                   op,
    input  logic [5:0]                   funct,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   shamt,
    input  logic [15:0]                  imm,
    input  logic [31:0]                  tgt,
    output logic                         imem_we,
    output logic [31:0]                  imem_addr,
    output logic [31:0]                  imem_wdata,
    output logic                         imem_re,
    input  logic [31:0]                  imem_rdata,
    output logic [31:0]                  pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         err_valid,
    output logic [2:0]                   err_code,
    output logic                         err_flag
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e         state_q;
    logic [1:0]     fmt_q;
    logic [5:0]     op_q, funct_q;
    logic [4:0]     rs_q, rt_q, rd_q, shamt_q;
    logic [15:0]    imm_q;
    logic [31:0]    tgt_q;
    logic [31:0]    pc_q, pc_d, addr_q, word_q;
    logic [CW-1:0]  count_q, count_d;
    logic           we_q, err_valid_q, err_flag_q;
    logic [2:0]     err_code_q;
    logic           full_w;
    logic [31:0]    pk_word;
    logic           pk_err;
    logic [2:0]     pk_code;

    instruction_field_packer u_packer (
        .fmt_i   (fmt_q),
        .op_i    (op_q),
        .funct_i (funct_q),
        .rs_i    (rs_q),
        .rt_i    (rt_q),
        .rd_i    (rd_q),
        .shamt_i (shamt_q),
        .imm_i   (imm_q),
        .tgt_i   (tgt_q),
        .pc_i    (pc_q),
        .word_o  (pk_word),
        .err_o   (pk_err),
        .code_o  (pk_code)
    );

    assign pc_d     = pc_q + 32'd4;
    assign count_d  = count_q + CW'(1);
    assign full_w   = (count_q == CW'(DEPTH));
    assign in_ready = (state_q == ST_IDLE) && !full_w && !load;

`ifdef READBACK_CHECK_EN
    logic re_q;
    assign imem_re = re_q & ~load;
`else
    logic unused_rdata;
    assign imem_re      = 1'b0;
    assign unused_rdata = ^imem_rdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fmt_q       <= '0;
            op_q        <= '0;
            funct_q     <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            shamt_q     <= '0;
            imm_q       <= '0;
            tgt_q       <= '0;
            pc_q        <= BASE_ADDR;
            addr_q      <= BASE_ADDR;
            word_q      <= '0;
            count_q     <= '0;
            we_q        <= 1'b0;
            err_valid_q <= 1'b0;
            err_flag_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
`ifdef READBACK_CHECK_EN
            re_q        <= 1'b0;
`endif
        end else begin
            we_q        <= 1'b0;
            err_valid_q <= 1'b0;
`ifdef READBACK_CHECK_EN
            re_q        <= 1'b0;
`endif
            if (load) begin
                state_q    <= ST_IDLE;
                pc_q       <= BASE_ADDR;
                count_q    <= '0;
                err_flag_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (in_valid && !full_w) begin
                            fmt_q   <= fmt;
                            op_q    <= op;
                            funct_q <= funct;
                            rs_q    <= rs;
                            rt_q    <= rt;
                            rd_q    <= rd;
                            shamt_q <= shamt;
                            imm_q   <= imm;
                            tgt_q   <= tgt;
                            state_q <= ST_ENC;
                        end
                    end
                    ST_ENC: begin
                        if (pk_err) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= pk_code;
                            err_flag_q  <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            word_q  <= pk_word;
                            addr_q  <= pc_q;
                            we_q    <= 1'b1;
                            state_q <= ST_WR;
                        end
                    end
                    ST_WR: begin
                        pc_q    <= pc_d;
                        count_q <= count_d;
`ifdef READBACK_CHECK_EN
                        re_q    <= 1'b1;
                        state_q <= ST_RD;
`else
                        state_q <= ST_IDLE;
`endif
                    end
`ifdef READBACK_CHECK_EN
                    ST_RD: state_q <= ST_CMP;
                    ST_CMP: begin
                        // Readback data lands the cycle after imem_re.
                        if (imem_rdata != word_q) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_RDBACK;
                            err_flag_q  <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
`endif
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // A load arriving during WR kills the write already in flight.
    assign imem_we    = we_q & ~load;
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign pc         = pc_q;
    assign count      = count_q;
    assign full       = full_w;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Scoreboard bench for instruction_encoder_loader (DEPTH=4).
// Readback cases run only when READBACK_CHECK_EN is defined.
module tb_instruction_encoder_loader;
    import instr_pkg::*;

`ifdef READBACK_CHECK_EN
    localparam int DONE = 5;
`else
    localparam int DONE = 3;
`endif

    logic        clk = 1'b0;
    logic        reset, load, in_valid, in_ready;
    logic [1:0]  fmt;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] tgt;
    logic        imem_we, imem_re;
    logic [31:0] imem_addr, imem_wdata, imem_rdata, pc;
    logic [2:0]  count;
    logic        full, err_valid, err_flag;
    logic [2:0]  err_code;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [31:0] mem [0:63];
    logic        corrupt = 1'b0;

    instruction_encoder_loader #(.BASE_ADDR(32'h0), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .load(load),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .tgt(tgt),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_re(imem_re),
        .imem_rdata(imem_rdata), .pc(pc), .count(count),
        .full(full), .err_valid(err_valid),
        .err_code(err_code), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we) mem[imem_addr[7:2]] <= imem_wdata;
        if (imem_re) imem_rdata <= mem[imem_addr[7:2]] ^ {31'b0, corrupt};
    end

    always @(negedge clk) begin
        if (imem_we) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write addr=%h data=%h, none expected",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== mon_e)
                begin
                    fails++;
                    $display("FAIL write addr/data=%h/%h required %h/%h",
                             imem_addr, imem_wdata, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [1:0] f, input logic [5:0] o,
                        input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] im,
                        input logic [31:0] tg);
        bit ok = 0;
        @(posedge clk); #1;
        fmt = f; op = o; rs = s; rt = t; rd = d;
        shamt = sh; funct = fn; imm = im; tgt = tg;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL send_timeout in_ready=0 required 1");
        end
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; in_valid = 1'b0;
        fmt = '0; op = '0; funct = '0; rs = '0; rt = '0; rd = '0;
        shamt = '0; imm = '0; tgt = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({pc, count, full} !== {32'h0, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_pc_count pc=%h cnt=%0d full=%b required 0/0/0", pc, count, full);
        end
        tests++;
        if ({imem_we, imem_re, err_valid, err_flag, err_code} !== 7'b0) begin
            fails++;
            $display("FAIL reset_strobes we=%b re=%b ev=%b ef=%b ec=%b required all 0",
                     imem_we, imem_re, err_valid, err_flag, err_code);
        end
        tests++;
        if (imem_wdata !== 32'h0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_wdata_ready wdata=%h rdy=%b required 0/1", imem_wdata, in_ready);
        end
    endtask

    task automatic test_r();
        exp_q.push_back({32'h0, 32'h0109_5020});
        send(FMT_R, OP_RTYPE, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 32'h0);
        @(negedge clk);
        tests++;
        if (imem_we !== 1'b0) begin
            fails++;
            $display("FAIL latency_enc we=%b required 0", imem_we);
        end
        @(negedge clk);
        tests++;
        if (imem_we !== 1'b1 || imem_re !== 1'b0) begin
            fails++;
            $display("FAIL latency_wr we=%b re=%b required 1/0", imem_we, imem_re);
        end
        repeat (DONE - 2) @(negedge clk);
        tests++;
        if (pc !== 32'h4 || count !== 3'd1) begin
            fails++;
            $display("FAIL r_pc_count pc=%h cnt=%0d required 4/1", pc, count);
        end
    endtask

    task automatic test_i();
        exp_q.push_back({32'h4, 32'h2008_0005});
        send(FMT_I, OP_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'd5, 32'h0);
        repeat (DONE) @(negedge clk);
        tests++;
        if (count !== 3'd2 || pc !== 32'h8 || err_flag !== 1'b0) begin
            fails++;
            $display("FAIL i_state cnt=%0d pc=%h ef=%b required 2/8/0", count, pc, err_flag);
        end
    endtask

    task automatic test_br();
        exp_q.push_back({32'h8, 32'h1509_FFFD});
        send(FMT_BR, OP_BNE, 5'd8, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0);
        repeat (DONE) @(negedge clk);
        tests++;
        if (pc !== 32'hC || count !== 3'd3) begin
            fails++;
            $display("FAIL br_state pc=%h cnt=%0d required C/3", pc, count);
        end
    endtask

    task automatic test_align_err();
        send(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h42);
        repeat (2) @(negedge clk);
        tests++;
        if ({err_valid, err_code, err_flag} !== {1'b1, ERR_ALIGN, 1'b1}) begin
            fails++;
            $display("FAIL align_err ev=%b ec=%b ef=%b required 1/001/1",
                     err_valid, err_code, err_flag);
        end
        tests++;
        if (pc !== 32'hC || count !== 3'd3) begin
            fails++;
            $display("FAIL align_noadv pc=%h cnt=%0d required C/3", pc, count);
        end
        @(negedge clk);
        tests++;
        if (err_valid !== 1'b0 || err_code !== ERR_ALIGN) begin
            fails++;
            $display("FAIL err_pulse ev=%b ec=%b required 0/001", err_valid, err_code);
        end
    endtask

    task automatic test_j();
        exp_q.push_back({32'hC, 32'h0800_0010});
        send(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h40);
        repeat (DONE) @(negedge clk);
        tests++;
        if (count !== 3'd4 || full !== 1'b1 || pc !== 32'h10) begin
            fails++;
            $display("FAIL j_full cnt=%0d full=%b pc=%h required 4/1/10", count, full, pc);
        end
    endtask

    task automatic test_full_load();
        @(posedge clk); #1;
        fmt = FMT_I; op = OP_ADDI; rs = 5'd1; rt = 5'd2; imm = 16'h7;
        in_valid = 1'b1;
        repeat (6) @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || count !== 3'd4 || err_flag !== 1'b1) begin
            fails++;
            $display("FAIL full_stall rdy=%b cnt=%0d ef=%b required 0/4/1",
                     in_ready, count, err_flag);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; load = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL load_ready rdy=%b required 0", in_ready);
        end
        @(posedge clk); #1 load = 1'b0;
        @(negedge clk);
        tests++;
        if ({pc, count, full, err_flag, in_ready} !== {32'h0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL load_clear pc=%h cnt=%0d full=%b ef=%b rdy=%b required 0/0/0/0/1",
                     pc, count, full, err_flag, in_ready);
        end
    endtask

    task automatic test_load_mid_wr();
        send(FMT_R, OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 32'h0);
        @(negedge clk);
        @(posedge clk); #1 load = 1'b1;
        @(negedge clk);
        tests++;
        if (imem_we !== 1'b0) begin
            fails++;
            $display("FAIL load_mid_wr we=%b required 0", imem_we);
        end
        @(posedge clk); #1 load = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (pc !== 32'h0 || count !== 3'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL load_mid_wr_state pc=%h cnt=%0d rdy=%b required 0/0/1",
                     pc, count, in_ready);
        end
    endtask

`ifdef READBACK_CHECK_EN
    task automatic test_readback();
        corrupt = 1'b1;
        exp_q.push_back({32'h0, 32'h0109_5020});
        send(FMT_R, OP_RTYPE, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 32'h0);
        repeat (3) @(negedge clk);
        tests++;
        if (imem_re !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL rb_re re=%b addr=%h required 1/0", imem_re, imem_addr);
        end
        repeat (2) @(negedge clk);
        tests++;
        if ({err_valid, err_code} !== {1'b1, ERR_RDBACK} || pc !== 32'h4 || count !== 3'd1) begin
            fails++;
            $display("FAIL rb_mismatch ev=%b ec=%b pc=%h cnt=%0d required 1/100/4/1",
                     err_valid, err_code, pc, count);
        end
        corrupt = 1'b0;
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask
`endif

    task automatic test_jump_region();
        send(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h1000_0000);
        repeat (2) @(negedge clk);
        tests++;
        if ({err_valid, err_code} !== {1'b1, ERR_JREGION} || pc !== 32'h0 || count !== 3'd0) begin
            fails++;
            $display("FAIL jregion ev=%b ec=%b pc=%h cnt=%0d required 1/011/0/0",
                     err_valid, err_code, pc, count);
        end
    endtask

    task automatic test_branch_range();
        logic [1:0]  ef [4] = '{FMT_BR, FMT_BR, FMT_BR, FMT_J};
        logic [31:0] et [4] = '{32'h0002_0004, 32'hFFFE_0000, 32'h0004_0001, 32'h1000_0002};
        logic [2:0]  ec [4] = '{ERR_BRANGE, ERR_BRANGE, ERR_ALIGN, ERR_ALIGN};
        for (int i = 0; i < 4; i++) begin
            send(ef[i], OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0, et[i]);
            repeat (2) @(negedge clk);
            tests++;
            if ({err_valid, err_code} !== {1'b1, ec[i]} || pc !== 32'h0) begin
                fails++;
                $display("FAIL range_err%0d ev=%b ec=%b pc=%h required 1/%b/0",
                         i, err_valid, err_code, pc, ec[i]);
            end
        end
        exp_q.push_back({32'h0, 32'h1022_7FFF});
        send(FMT_BR, OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0002_0000);
        repeat (DONE) @(negedge clk);
        exp_q.push_back({32'h4, 32'h1022_8000});
        send(FMT_BR, OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0, 32'hFFFE_0008);
        repeat (DONE) @(negedge clk);
        tests++;
        if (pc !== 32'h8 || count !== 3'd2 || err_valid !== 1'b0) begin
            fails++;
            $display("FAIL range_edges pc=%h cnt=%0d ev=%b required 8/2/0", pc, count, err_valid);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int nwe = 0;
        int w0 = 0;
        int w1 = 0;
        exp_q.push_back({32'h8, 32'h2003_1234});
        exp_q.push_back({32'hC, 32'h2003_1234});
        @(posedge clk); #1;
        fmt = FMT_I; op = OP_ADDI; rs = 5'd0; rt = 5'd3; imm = 16'h1234;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            if (imem_we) begin
                if (nwe == 0) w0 = i; else w1 = i;
                nwe++;
            end
            if (nwe == 2) break;
            @(posedge clk); #1;
            if (acc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        tests++;
        if (nwe != 2 || (w1 - w0) != DONE) begin
            fails++;
            $display("FAIL b2b writes=%0d spacing=%0d required 2/%0d", nwe, w1 - w0, DONE);
        end
        repeat (DONE - 2) @(negedge clk);
        tests++;
        if (count !== 3'd4 || full !== 1'b1 || pc !== 32'h10) begin
            fails++;
            $display("FAIL b2b_full cnt=%0d full=%b pc=%h required 4/1/10", count, full, pc);
        end
    endtask

    initial begin
        test_reset();
        test_r();
        test_i();
        test_br();
        test_align_err();
        test_j();
        test_full_load();
        test_load_mid_wr();
`ifdef READBACK_CHECK_EN
        test_readback();
`endif
        test_jump_region();
        test_branch_range();
        test_back_to_back();
        repeat (4) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
